// File: rtl/esn7e_demo_system_nios2_qsys_jtag_ocimem_ctrl.sv
// JTAG debug-RAM access controller: sequences single-word writes and reads for the OCI.
// Define JTAG_OCIMEM_AUTOINC_EN to advance the word address after each completed access.
module esn7e_demo_system_nios2_qsys_jtag_ocimem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {IDLE, WR, RD, RDCAP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] w_addr_adv;
    logic [31:0]       r_mon;
    logic [31:0]       w_mon_nxt;
    logic              r_ready;
    logic              w_ready_nxt;
    logic              r_error;
    logic              w_error_nxt;
    logic              w_any;
    logic              w_unused;

`ifdef JTAG_OCIMEM_AUTOINC_EN
    assign w_addr_adv = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
`else
    assign w_addr_adv = r_addr;
`endif

    assign w_any    = take_action_ocimem_a | take_action_ocimem_b
                    | take_no_action_ocimem_a;
    assign w_unused = ^{jdo[37:36], jdo[2:0]};

    always_comb begin
        w_next      = r_state;
        w_addr_nxt  = r_addr;
        w_mon_nxt   = r_mon;
        w_ready_nxt = r_ready;
        w_error_nxt = r_error;
        unique case (r_state)
            IDLE: begin
                if (take_action_ocimem_b) begin
                    w_mon_nxt   = jdo[34:3];
                    w_ready_nxt = 1'b0;
                    w_next      = WR;
                end else if (take_action_ocimem_a) begin
                    w_addr_nxt  = jdo[ADDR_W+17:18];
                    w_error_nxt = 1'b0;
                    if (jdo[35]) begin
                        w_ready_nxt = 1'b0;
                        w_next      = RD;
                    end else begin
                        w_ready_nxt = 1'b1;
                    end
                end else if (take_no_action_ocimem_a) begin
                    w_ready_nxt = 1'b0;
                    w_next      = RD;
                end
            end
            WR: begin
                w_ready_nxt = 1'b1;
                w_addr_nxt  = w_addr_adv;
                w_next      = IDLE;
            end
            RD: begin
                w_next = RDCAP;
            end
            RDCAP: begin
                w_mon_nxt   = ram_rdata;
                w_ready_nxt = 1'b1;
                w_addr_nxt  = w_addr_adv;
                w_next      = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        // Strobes arriving mid-access are dropped but remembered.
        if (r_state != IDLE && w_any) begin
            w_error_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_mon   <= '0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_addr  <= w_addr_nxt;
            r_mon   <= w_mon_nxt;
            r_ready <= w_ready_nxt;
            r_error <= w_error_nxt;
        end
    end

    assign ram_addr      = r_addr;
    assign ram_wdata     = r_mon;
    assign ram_we        = (r_state == WR);
    assign ram_re        = (r_state == RD);
    assign MonDReg       = r_mon;
    assign monitor_ready = r_ready;
    assign monitor_error = r_error;

endmodule

// File: tb/tb_esn7e_demo_system_nios2_qsys_jtag_ocimem_ctrl.sv
// Directed bench for the JTAG debug-RAM controller with a transaction-level reference.
// Honours JTAG_OCIMEM_AUTOINC_EN when it is defined for the build.
module tb_esn7e_demo_system_nios2_qsys_jtag_ocimem_ctrl;

`ifdef JTAG_OCIMEM_AUTOINC_EN
    localparam int AI = 1;
`else
    localparam int AI = 0;
`endif

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        sa, sb, sna;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we, ram_re;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    int checks = 0;
    int errors = 0;
    int re_cnt = 0;
    int re_snap;

    logic [31:0] mem   [256];
    logic [31:0] m_mem [256];

    // reference state: m_ph counts edges left until the controller is idle again
    int          m_ph   = 0;
    bit          m_wr   = 0;
    logic [7:0]  m_addr = 0;
    logic [31:0] m_mon  = 0;
    bit          m_rdy  = 0;
    bit          m_err  = 0;

    esn7e_demo_system_nios2_qsys_jtag_ocimem_ctrl #(.ADDR_W(8)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .jdo                    (jdo),
        .take_action_ocimem_a   (sa),
        .take_action_ocimem_b   (sb),
        .take_no_action_ocimem_a(sna),
        .ram_addr               (ram_addr),
        .ram_wdata              (ram_wdata),
        .ram_we                 (ram_we),
        .ram_re                 (ram_re),
        .ram_rdata              (ram_rdata),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word0(input int i);
        case (i)
            8'h11:   return 32'h12345678;
            8'hFF:   return 32'hCAFEF00D;
            8'h20:   return 32'hA1A1A1A1;
            8'h21:   return 32'hB2B2B2B2;
            default: return 32'(i) * 32'h9E3779B1;
        endcase
    endfunction

    function automatic logic [37:0] ja(input logic [7:0] a, input bit rd);
        logic [37:0] j;
        j = '0;
        j[25:18] = a;
        j[35] = rd;
        return j;
    endfunction

    function automatic logic [37:0] jb(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // debug RAM: one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
        if (ram_re) re_cnt <= re_cnt + 1;
    end

    // reference model
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_ph = 0; m_wr = 0; m_addr = 0; m_mon = 0; m_rdy = 0; m_err = 0;
        end else if (m_ph == 0) begin
            if (sb) begin
                m_mon = jdo[34:3]; m_rdy = 0; m_wr = 1; m_ph = 1;
            end else if (sa) begin
                m_addr = jdo[25:18];
                m_err  = 0;
                if (jdo[35]) begin
                    m_rdy = 0; m_wr = 0; m_ph = 2;
                end else begin
                    m_rdy = 1;
                end
            end else if (sna) begin
                m_rdy = 0; m_wr = 0; m_ph = 2;
            end
        end else begin
            if (sa | sb | sna) m_err = 1;
            if (m_ph == 1) begin
                if (m_wr) m_mem[m_addr] = m_mon;
                else      m_mon = m_mem[m_addr];
                m_rdy  = 1;
                m_addr = m_addr + 8'(AI);
            end
            m_ph--;
        end
    end

    // compare DUT against the reference every cycle
    initial forever begin
        @(negedge clk);
        chk("ram_addr", 32'(ram_addr), 32'(m_addr));
        chk("MonDReg", MonDReg, m_mon);
        chk("ram_wdata", ram_wdata, m_mon);
        chk("ram_we", 32'(ram_we), 32'(m_wr && m_ph == 1));
        chk("ram_re", 32'(ram_re), 32'(m_ph == 2));
        chk("ready", 32'(monitor_ready), 32'(m_rdy));
        chk("error", 32'(monitor_error), 32'(m_err));
        chk("we_re_excl", 32'(ram_we & ram_re), 32'd0);
    end

    task automatic pulse(input bit a, input bit b, input bit na,
                         input logic [37:0] j);
        sa = a; sb = b; sna = na; jdo = j;
        @(negedge clk);
        sa = 0; sb = 0; sna = 0; jdo = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]   = word0(i);
            m_mem[i] = word0(i);
        end
        reset_n = 0; sa = 0; sb = 0; sna = 0; jdo = '0;
        #7;
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_mon", MonDReg, 32'd0);
        chk("rst_ready", 32'(monitor_ready), 32'd0);
        chk("rst_we_re", 32'({ram_we, ram_re}), 32'd0);
        idle(2);
        reset_n = 1;
        idle(1);

        // set address, then write
        pulse(1, 0, 0, ja(8'h10, 0));
        chk("seta_ready", 32'(monitor_ready), 32'd1);
        chk("seta_addr", 32'(ram_addr), 32'h10);
        pulse(0, 1, 0, jb(32'hDEADBEEF));
        chk("wr_we", 32'(ram_we), 32'd1);
        chk("wr_addr", 32'(ram_addr), 32'h10);
        chk("wr_wdata", ram_wdata, 32'hDEADBEEF);
        chk("wr_ready_lo", 32'(monitor_ready), 32'd0);
        idle(1);
        chk("wr_we_off", 32'(ram_we), 32'd0);
        chk("wr_ready_hi", 32'(monitor_ready), 32'd1);
        chk("wr_mem", mem[8'h10], 32'hDEADBEEF);
        chk("wr_addr_adv", 32'(ram_addr), 32'h10 + AI);

        // read
        pulse(1, 0, 0, ja(8'h11, 1));
        chk("rd_re", 32'(ram_re), 32'd1);
        chk("rd_addr", 32'(ram_addr), 32'h11);
        idle(1);
        chk("rd_re_off", 32'(ram_re), 32'd0);
        chk("rd_ready_lo", 32'(monitor_ready), 32'd0);
        idle(1);
        chk("rd_ready_hi", 32'(monitor_ready), 32'd1);
        chk("rd_data", MonDReg, 32'h12345678);
        chk("rd_addr_adv", 32'(ram_addr), 32'h11 + AI);

        // wrap
        pulse(1, 0, 0, ja(8'hFF, 0));
        pulse(0, 0, 1, '0);
        chk("wrap_re", 32'(ram_re), 32'd1);
        chk("wrap_addr", 32'(ram_addr), 32'hFF);
        idle(2);
        chk("wrap_data", MonDReg, 32'hCAFEF00D);
        chk("wrap_addr_adv", 32'(ram_addr), AI == 1 ? 32'h00 : 32'hFF);

        // collision
        pulse(0, 1, 0, jb(32'h55AA55AA));
        pulse(1, 0, 0, ja(8'h40, 1));
        chk("col_err", 32'(monitor_error), 32'd1);
        chk("col_addr", 32'(ram_addr), AI == 1 ? 32'h01 : 32'hFF);
        idle(1);
        pulse(1, 0, 0, ja(8'h30, 0));
        chk("col_clear", 32'(monitor_error), 32'd0);
        chk("col_newaddr", 32'(ram_addr), 32'h30);

        // simultaneous a and b
        pulse(1, 1, 0, jb(32'h13572468));
        chk("sim_we", 32'(ram_we), 32'd1);
        chk("sim_re", 32'(ram_re), 32'd0);
        chk("sim_err", 32'(monitor_error), 32'd0);
        chk("sim_addr", 32'(ram_addr), 32'h30);
        idle(1);
        chk("sim_mem", mem[8'h30], 32'h13572468);

        // reset in the middle of a read
        pulse(1, 0, 0, ja(8'h20, 1));
        chk("mid_re", 32'(ram_re), 32'd1);
        #1 reset_n = 0;
        #1;
        chk("mid_rst_re", 32'(ram_re), 32'd0);
        chk("mid_rst_addr", 32'(ram_addr), 32'd0);
        chk("mid_rst_mon", MonDReg, 32'd0);
        chk("mid_rst_flags", 32'({monitor_ready, monitor_error, ram_we}), 32'd0);
        idle(1);
        reset_n = 1;
        re_snap = re_cnt;
        idle(3);
        chk("mid_no_re", 32'(re_cnt - re_snap), 32'd0);
        pulse(1, 0, 0, ja(8'h20, 1));
        idle(2);
        chk("rr_first", MonDReg, 32'hA1A1A1A1);
        pulse(0, 0, 1, '0);
        idle(2);
        chk("rr_second", MonDReg, AI == 1 ? 32'hB2B2B2B2 : 32'hA1A1A1A1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
